// File: rtl/hazard_pkg.sv
// Shared constants for hazard detection and operand selection:
// forwarding codes, controller states and the shadow-pipeline entry.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 16;

  // Forwarding codes: stage distance, producer kind, operand A/B
  localparam logic [CODE_W-1:0] FWD_NONE = 4'h0;
  localparam logic [CODE_W-1:0] FWD_E_A  = 4'h1;
  localparam logic [CODE_W-1:0] FWD_E_B  = 4'h2;
  localparam logic [CODE_W-1:0] FWD_M_A  = 4'h5;
  localparam logic [CODE_W-1:0] FWD_M_B  = 4'h6;
  localparam logic [CODE_W-1:0] FWD_ML_A = 4'h7;
  localparam logic [CODE_W-1:0] FWD_ML_B = 4'h8;
  localparam logic [CODE_W-1:0] FWD_W_A  = 4'h9;
  localparam logic [CODE_W-1:0] FWD_W_B  = 4'hA;
  localparam logic [CODE_W-1:0] FWD_WL_A = 4'hB;
  localparam logic [CODE_W-1:0] FWD_WL_B = 4'hC;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_DUAL_STALL = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } shadow_t;

endpackage

// File: rtl/fwd_lookup.sv
// Per-operand lookup: finds the nearest in-flight producer of a source
// register and turns its distance and kind into a forwarding code.
module fwd_lookup
  import hazard_pkg::*;
#(
  parameter bit IS_B = 1'b0
) (
  input  logic [REG_W-1:0]  reg_i,
  input  logic              uses_i,
  input  shadow_t           e_i,
  input  shadow_t           m_i,
  input  shadow_t           w_i,
  output logic [CODE_W-1:0] code_o,
  output logic              needs_fwd_o,
  output logic              load_use_o
);

  logic active;
  logic hit_e;
  logic hit_m;
  logic hit_w;

  assign active = uses_i && (reg_i != '0);
  assign hit_e  = active && e_i.valid && (e_i.dest == reg_i);
  assign hit_m  = active && m_i.valid && (m_i.dest == reg_i);
  assign hit_w  = active && w_i.valid && (w_i.dest == reg_i);

  // Nearest stage wins; a load one stage ahead has no code, only a stall
  always_comb begin
    code_o      = FWD_NONE;
    needs_fwd_o = 1'b0;
    load_use_o  = 1'b0;
    if (hit_e) begin
      needs_fwd_o = 1'b1;
      if (e_i.is_load) load_use_o = 1'b1;
      else             code_o     = IS_B ? FWD_E_B : FWD_E_A;
    end else if (hit_m) begin
      needs_fwd_o = 1'b1;
      if (m_i.is_load) code_o = IS_B ? FWD_ML_B : FWD_ML_A;
      else             code_o = IS_B ? FWD_M_B  : FWD_M_A;
    end else if (hit_w) begin
      needs_fwd_o = 1'b1;
      if (w_i.is_load) code_o = IS_B ? FWD_WL_B : FWD_WL_A;
      else             code_o = IS_B ? FWD_W_B  : FWD_W_A;
    end
  end

endmodule

// File: rtl/hazard_detector.sv
// Decode-stage hazard detector: tracks in-flight destinations, emits the
// registered forwarding code for E and stalls on load-use or dual hazards.
module hazard_detector
  import hazard_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_W-1:0]  RsD,
  input  logic [REG_W-1:0]  RtD,
  input  logic              UsesRsD,
  input  logic              UsesRtD,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic [REG_W-1:0]  WriteRegD,
  output logic [CODE_W-1:0] ForwardTypeE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCnt
);

  shadow_t           sh_e_q, sh_m_q, sh_w_q, sh_e_d;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] fwd_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [CODE_W-1:0] code_a, code_b;
  logic              needs_a, needs_b, lu_a, lu_b;
  logic              load_use, dual, stall_c;

  fwd_lookup #(.IS_B(1'b0)) u_fwd_a (
    .reg_i(RsD), .uses_i(UsesRsD), .e_i(sh_e_q), .m_i(sh_m_q), .w_i(sh_w_q),
    .code_o(code_a), .needs_fwd_o(needs_a), .load_use_o(lu_a)
  );

  fwd_lookup #(.IS_B(1'b1)) u_fwd_b (
    .reg_i(RtD), .uses_i(UsesRtD), .e_i(sh_e_q), .m_i(sh_m_q), .w_i(sh_w_q),
    .code_o(code_b), .needs_fwd_o(needs_b), .load_use_o(lu_b)
  );

  assign load_use = lu_a | lu_b;
  assign dual     = needs_a & needs_b;

  // Held D is re-evaluated every cycle; being headed for a stall state is the stall
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:        state_d = load_use ? ST_LOAD_STALL : (dual ? ST_DUAL_STALL : ST_RUN);
      ST_LOAD_STALL: state_d = load_use ? ST_LOAD_STALL : (dual ? ST_DUAL_STALL : ST_RUN);
      ST_DUAL_STALL: state_d = dual ? ST_DUAL_STALL : ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  assign stall_c = (state_d != ST_RUN);
  assign StallF  = stall_c;
  assign StallD  = stall_c;
  assign FlushE  = stall_c;

  always_comb begin
    sh_e_d = '0;
    fwd_d  = FWD_NONE;
    cnt_d  = StallCnt;
    if (!stall_c) begin
      if (RegWriteD && (WriteRegD != '0)) sh_e_d = '{valid: 1'b1, dest: WriteRegD, is_load: MemToRegD};
      fwd_d = needs_a ? code_a : code_b;
    end else if (StallCnt != '1) begin
      cnt_d = StallCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_RUN;
      sh_e_q       <= '0;
      sh_m_q       <= '0;
      sh_w_q       <= '0;
      ForwardTypeE <= FWD_NONE;
      StallCnt     <= '0;
    end else begin
      state_q      <= state_d;
      sh_e_q       <= sh_e_d;
      sh_m_q       <= sh_e_q;
      sh_w_q       <= sh_m_q;
      ForwardTypeE <= fwd_d;
      StallCnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_detector.sv
// Bench for hazard_detector: directed instruction table, reset-in-stall
// sequence, then random traffic against a history-based reference model.
module tb_hazard_detector;
  import hazard_pkg::*;

  logic        Clk;
  logic        Reset;
  logic [4:0]  RsD, RtD, WriteRegD;
  logic        UsesRsD, UsesRtD, RegWriteD, MemToRegD;
  logic [3:0]  ForwardTypeE;
  logic        StallF, StallD, FlushE;
  logic [15:0] StallCnt;

  int checks = 0;
  int errors = 0;

  hazard_detector dut (
    .Clk(Clk), .Reset(Reset), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD),
    .UsesRtD(UsesRtD), .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
    .WriteRegD(WriteRegD), .ForwardTypeE(ForwardTypeE), .StallF(StallF),
    .StallD(StallD), .FlushE(FlushE), .StallCnt(StallCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  rs, rt;
    logic        urs, urt, rw, ml;
    logic [4:0]  wr;
    logic        st;
    logic [3:0]  fwd;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       ld;
  } ent_t;

  vec_t tbl[$];
  ent_t hist [3];

  function automatic vec_t mk(input int rs, rt, urs, urt, rw, ml, wr, st, fwd, cnt);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt);
    v.rw = 1'(rw); v.ml = 1'(ml); v.wr = 5'(wr);
    v.st = 1'(st); v.fwd = 4'(fwd); v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    RsD = v.rs; RtD = v.rt; UsesRsD = v.urs; UsesRtD = v.urt;
    RegWriteD = v.rw; MemToRegD = v.ml; WriteRegD = v.wr;
  endtask

  task automatic check_outs(input string tag, input logic st, input logic [3:0] fwd,
                            input logic [15:0] cnt);
    chk({tag, "_StallF"}, 16'(StallF), 16'(st));
    chk({tag, "_StallD"}, 16'(StallD), 16'(st));
    chk({tag, "_FlushE"}, 16'(FlushE), 16'(st));
    chk({tag, "_ForwardTypeE"}, 16'(ForwardTypeE), 16'(fwd));
    chk({tag, "_StallCnt"}, StallCnt, cnt);
  endtask

  // Reference: distance = position of the newest matching producer in issue history
  function automatic int operand_dist(input logic [4:0] r, input logic u, output logic ld);
    ld = 1'b0;
    if (!u || r == 5'd0) return 0;
    for (int k = 0; k < 3; k++) begin
      if (hist[k].v && hist[k].d == r) begin
        ld = hist[k].ld;
        return k + 1;
      end
    end
    return 0;
  endfunction

  initial begin
    int da, db, ec;
    logic la, lb, e_stall, prev_stall;
    logic [3:0]  m_fwd;
    logic [15:0] m_cnt;
    vec_t nop;

    nop = mk(0,0,0,0,0,0,0, 0,0,0);
    Reset = 1'b1;
    drive(nop);
    #2;
    check_outs("reset", 1'b0, 4'h0, 16'h0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;

    //        rs rt urs urt rw ml wr   st fwd cnt
    tbl.push_back(mk(1,2,1,1,1,0,3,   0,0,0));   // add r3
    tbl.push_back(mk(3,0,1,1,1,0,7,   0,0,0));   // sub r7,r3,r0
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,1,0));   // nop: sub sees code 1
    tbl.push_back(mk(0,0,1,0,1,1,5,   0,0,0));   // lw r5
    tbl.push_back(mk(1,5,1,1,1,0,6,   1,0,0));   // add r6,r1,r5: load-use
    tbl.push_back(mk(1,5,1,1,1,0,6,   0,0,1));   // held, now d2 load
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,8,1));
    tbl.push_back(mk(1,2,1,1,1,0,4,   0,0,1));   // or r4
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,1));
    tbl.push_back(mk(4,0,1,0,0,0,0,   0,0,1));   // consumer at d3
    tbl.push_back(mk(1,2,1,1,1,0,4,   0,9,1));   // or r4 again
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,1));
    tbl.push_back(mk(4,0,1,0,0,0,0,   0,0,1));   // consumer at d4
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,1));
    tbl.push_back(mk(0,0,1,1,1,0,1,   0,0,1));   // add r1
    tbl.push_back(mk(0,0,1,1,1,0,2,   0,0,1));   // add r2
    tbl.push_back(mk(1,2,1,1,1,0,6,   1,0,1));   // sub r6,r1,r2: dual
    tbl.push_back(mk(1,2,1,1,1,0,6,   1,0,2));
    tbl.push_back(mk(1,2,1,1,1,0,6,   0,0,3));   // r2 alone at d3
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,10,3));
    tbl.push_back(mk(0,0,1,1,1,0,0,   0,0,3));   // add r0
    tbl.push_back(mk(0,0,1,1,0,0,0,   0,0,3));   // reads r0
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,3));
    tbl.push_back(mk(0,0,1,0,1,1,5,   0,0,3));   // lw r5
    tbl.push_back(mk(5,5,0,0,0,0,0,   0,0,3));   // names r5 but uses neither
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,3));
    tbl.push_back(mk(0,0,1,1,1,0,3,   0,0,3));   // add r3
    tbl.push_back(mk(3,3,1,1,1,0,9,   1,0,3));   // add r9,r3,r3
    tbl.push_back(mk(3,3,1,1,1,0,9,   1,0,4));
    tbl.push_back(mk(3,3,1,1,1,0,9,   1,0,5));
    tbl.push_back(mk(3,3,1,1,1,0,9,   0,0,6));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,6));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge Clk);
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].fwd, tbl[i].cnt);
      @(posedge Clk); #1;
    end

    // Reset in the middle of a load-use stall
    drive(mk(0,0,1,0,1,1,5, 0,0,0));
    @(posedge Clk); #1;
    drive(mk(0,5,0,1,1,0,6, 0,0,0));
    @(negedge Clk);
    chk("ls_stall", 16'(StallF), 16'h1);
    #1 Reset = 1'b1;
    #1;
    check_outs("ls_reset", 1'b0, 4'h0, 16'h0);
    chk("ls_reset_state", 16'(dut.state_q), 16'(ST_RUN));
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_outs("post_reset", 1'b0, 4'h0, 16'h0);
    @(posedge Clk); #1;
    drive(nop);
    @(negedge Clk);
    check_outs("post_reset_code", 1'b0, 4'h0, 16'h0);

    // Random traffic against the history model
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_fwd = 4'h0;
    m_cnt = 16'h0;
    prev_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!prev_stall) begin
        RsD       = 5'($urandom_range(0, 7));
        RtD       = 5'($urandom_range(0, 7));
        UsesRsD   = ($urandom_range(0, 3) != 0);
        UsesRtD   = ($urandom_range(0, 3) != 0);
        RegWriteD = ($urandom_range(0, 3) != 0);
        MemToRegD = ($urandom_range(0, 2) == 0);
        WriteRegD = 5'($urandom_range(0, 7));
      end
      da = operand_dist(RsD, UsesRsD, la);
      db = operand_dist(RtD, UsesRtD, lb);
      e_stall = ((da == 1) && la) || ((db == 1) && lb) || ((da != 0) && (db != 0));
      if (e_stall)      ec = 0;
      else if (da != 0) ec = 4 * da - 3 + (la ? 2 : 0);
      else if (db != 0) ec = 4 * db - 2 + (lb ? 2 : 0);
      else              ec = 0;
      @(negedge Clk);
      chk("rand_stall", 16'(StallF), 16'(e_stall));
      chk("rand_flush", 16'(FlushE), 16'(e_stall));
      chk("rand_fwd", 16'(ForwardTypeE), 16'(m_fwd));
      chk("rand_cnt", StallCnt, m_cnt);
      @(posedge Clk);
      m_fwd = 4'(ec);
      if (e_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (!e_stall && RegWriteD && WriteRegD != 5'd0)
        hist[0] = '{v: 1'b1, d: WriteRegD, ld: MemToRegD};
      else
        hist[0] = '0;
      prev_stall = e_stall;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
